// File: rtl/fx2_fifo_responder.sv
// fx2_fifo_responder
// Peripheral end of the Cypress FX2 slave-FIFO bus. EP2 (host -> FPGA) is
// filled from a host valid/ready stream and drained by FX2 reads. EP6
// (FPGA -> host) is filled by FX2 writes and drained by a host stream that
// carries a packet-end marker. FLAGA..FLAGD are decoded from the
// registered FIFO levels.
//
// Handshake semantics (both host streams): a word moves on a rising clk
// edge where valid and ready are both high. The source holds data stable
// while valid is high and ready is low. Ready never depends on valid.
module fx2_fifo_responder #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fx2_slcs_n,
    input  logic                  fx2_slrd_n,
    input  logic                  fx2_slwr_n,
    input  logic                  fx2_sloe_n,
    input  logic                  fx2_pktend_n,
    input  logic [1:0]            fx2_a,
    inout  wire  [15:0]           fx2_db,
    output logic                  fx2_flaga,
    output logic                  fx2_flagb,
    output logic                  fx2_flagc,
    output logic                  fx2_flagd,
    input  logic                  host_wr_valid,
    input  logic [15:0]           host_wr_data,
    output logic                  host_wr_ready,
    output logic                  host_rd_valid,
    output logic [15:0]           host_rd_data,
    output logic                  host_rd_last,
    input  logic                  host_rd_ready,
    output logic [DEPTH_LOG2:0]   ep2_level,
    output logic [DEPTH_LOG2:0]   ep6_level,
    output logic                  proto_err
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    localparam logic [1:0] ADDR_EP2 = 2'b00;
    localparam logic [1:0] ADDR_EP6 = 2'b10;

    // Storage: data RAMs carry no reset; EP6 last bits are flops so that
    // reset clears every packet marker.
    logic [15:0]           ep2_mem [DEPTH];
    logic [15:0]           ep6_mem [DEPTH];
    logic [DEPTH-1:0]      ep6_last;

    logic [DEPTH_LOG2-1:0] ep2_wr_ptr, ep2_rd_ptr;
    logic [DEPTH_LOG2-1:0] ep6_wr_ptr, ep6_rd_ptr;
    logic [DEPTH_LOG2-1:0] ep6_prev_ptr;

    logic fx2_sel;
    logic violation;
    logic ep2_push, ep2_pop;
    logic ep6_push, ep6_pop;
    logic pktend_hit;
    logic db_oe;
    logic [15:0] db_out;

    // Flags straight from the registered levels.
    assign fx2_flaga = (ep2_level != '0);
    assign fx2_flagc = (ep2_level == FULL_LEVEL);
    assign fx2_flagb = (ep6_level != FULL_LEVEL);
    assign fx2_flagd = (ep6_level == '0);

    assign host_wr_ready = !fx2_flagc;
    assign host_rd_valid = !fx2_flagd;
    // Head words are masked while empty so stale RAM never leaks out.
    assign host_rd_data  = fx2_flagd ? 16'h0000 : ep6_mem[ep6_rd_ptr];
    assign host_rd_last  = !fx2_flagd && ep6_last[ep6_rd_ptr];

    // FX2 strobe decode; a violating cycle moves no FX2 data.
    assign fx2_sel   = !fx2_slcs_n;
    assign violation = fx2_sel && (
                           (!fx2_slrd_n && !fx2_slwr_n) ||
                           (!fx2_slrd_n && (fx2_a != ADDR_EP2)) ||
                           (!fx2_slwr_n && (fx2_a != ADDR_EP6)) ||
                           (!fx2_sloe_n && !fx2_slwr_n));

    assign ep2_push   = host_wr_valid && host_wr_ready;
    assign ep2_pop    = fx2_sel && !fx2_slrd_n && (fx2_a == ADDR_EP2) &&
                        fx2_flaga && !violation;
    assign ep6_push   = fx2_sel && !fx2_slwr_n && (fx2_a == ADDR_EP6) &&
                        fx2_flagb && !violation;
    assign ep6_pop    = host_rd_valid && host_rd_ready;
    assign pktend_hit = fx2_sel && !fx2_pktend_n && (fx2_a == ADDR_EP6);

    assign ep6_prev_ptr = ep6_wr_ptr - PTR_ONE;

    // fx2_db: EP2 head, first-word-fall-through, only while output-enabled.
    assign db_oe  = fx2_sel && !fx2_sloe_n && (fx2_a == ADDR_EP2);
    assign db_out = fx2_flaga ? ep2_mem[ep2_rd_ptr] : 16'h0000;
    assign fx2_db = db_oe ? db_out : 16'hzzzz;

    // EP2 data RAM write port (host side).
    always_ff @(posedge clk) begin
        if (ep2_push) begin
            ep2_mem[ep2_wr_ptr] <= host_wr_data;
        end
    end

    // EP6 data RAM write port (FX2 side).
    always_ff @(posedge clk) begin
        if (ep6_push) begin
            ep6_mem[ep6_wr_ptr] <= fx2_db;
        end
    end

    // EP6 packet-end markers: a push writes its own marker, otherwise
    // PKTEND tags the most recently written entry when EP6 is not empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ep6_last <= '0;
        end else if (ep6_push) begin
            ep6_last[ep6_wr_ptr] <= pktend_hit;
        end else if (pktend_hit && (ep6_level != '0)) begin
            ep6_last[ep6_prev_ptr] <= 1'b1;
        end
    end

    // EP2 pointers and level; simultaneous push and pop leave the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ep2_wr_ptr <= '0;
            ep2_rd_ptr <= '0;
            ep2_level  <= '0;
        end else begin
            if (ep2_push) ep2_wr_ptr <= ep2_wr_ptr + PTR_ONE;
            if (ep2_pop)  ep2_rd_ptr <= ep2_rd_ptr + PTR_ONE;
            case ({ep2_push, ep2_pop})
                2'b10:   ep2_level <= ep2_level + LVL_ONE;
                2'b01:   ep2_level <= ep2_level - LVL_ONE;
                default: ep2_level <= ep2_level;
            endcase
        end
    end

    // EP6 pointers and level; simultaneous push and pop leave the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ep6_wr_ptr <= '0;
            ep6_rd_ptr <= '0;
            ep6_level  <= '0;
        end else begin
            if (ep6_push) ep6_wr_ptr <= ep6_wr_ptr + PTR_ONE;
            if (ep6_pop)  ep6_rd_ptr <= ep6_rd_ptr + PTR_ONE;
            case ({ep6_push, ep6_pop})
                2'b10:   ep6_level <= ep6_level + LVL_ONE;
                2'b01:   ep6_level <= ep6_level - LVL_ONE;
                default: ep6_level <= ep6_level;
            endcase
        end
    end

    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (violation) begin
            proto_err <= 1'b1;
        end
    end

endmodule
